// File: rtl/fix_to_float_if.sv
// fix_to_float_if: handshake bundle for fix_to_float.
// in_valid/in_ready/in_data : Q6.2 sample stream into the converter
// out_valid/out_ready/out   : float8 result stream out of the converter
// master = producer/consumer side (testbench), slave = converter side.
interface fix_to_float_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/fix_to_float.sv
// fix_to_float: converts signed Q6.2 fixed point to float8 {sign, exp bias 3, 4-bit fraction}.
// Ports: clkn (clock, posedge), rst (async active-high), bus (fix_to_float_if.slave).
// FIX_TO_FLOAT_ROUND_EN defined: round half-up in magnitude; undefined: truncate.
module fix_to_float (
    input logic           clkn,
    input logic           rst,
    fix_to_float_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;
    state_t     state, state_n;
    logic       sign, sign_n;
    logic [7:0] sr, sr_n, res, res_n, mag_in;
    logic [2:0] cnt, cnt_n;
    logic [6:0] ef;
    assign mag_in = bus.in_data[7] ? 8'(-bus.in_data) : bus.in_data;
    // {exponent, fraction} packed together so a rounding carry out of the
    // fraction ripples straight into the exponent.
`ifdef FIX_TO_FLOAT_ROUND_EN
    assign ef = {cnt + 3'd1, sr[6:3]} + 7'(sr[2]);
`else
    assign ef = {cnt + 3'd1, sr[6:3]};
`endif
    assign bus.out = res;
    always_comb begin
        state_n = state;
        sign_n = sign;
        sr_n = sr;
        cnt_n = cnt;
        res_n = res;
        bus.in_ready = state == IDLE;
        bus.out_valid = state == DONE;
        unique case (state)
            IDLE: if (bus.in_valid) begin
                sign_n = bus.in_data[7];
                sr_n = mag_in;
                cnt_n = 3'd7;
                state_n = (mag_in == 8'd0 || mag_in >= 8'd64) ? PACK : NORM;
            end
            // Leave on the same edge as the shift that brings the leading 1 into bit 7.
            NORM: if (sr[7]) state_n = PACK;
            else begin
                sr_n = sr << 1;
                cnt_n = cnt - 3'd1;
                state_n = sr[6] ? PACK : NORM;
            end
            // cnt still 7 means no normalisation ran: the input was zero or overflowed.
            PACK: begin
                res_n = cnt == 3'd7 ? (sr == 8'd0 ? 8'h00 : {sign, 7'h70}) :
                        ef[6:4] == 3'b111 ? {sign, 7'h70} : {sign, ef};
                state_n = DONE;
            end
            DONE: if (bus.out_ready) state_n = IDLE;
        endcase
    end
    always_ff @(posedge clkn or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sign <= 1'b0;
            sr <= 8'd0;
            cnt <= 3'd0;
            res <= 8'd0;
        end else begin
            state <= state_n;
            sign <= sign_n;
            sr <= sr_n;
            cnt <= cnt_n;
            res <= res_n;
        end
    end
endmodule
